// File: rtl/spwm_speed_sequencer.sv
// Soft-start/soft-stop sequencer for one SPWM channel: ramps freq_adj one
// step per STEP_HOLD cycles toward target_sel, with latched emergency stop.
module spwm_speed_sequencer #(
  parameter int unsigned STEP_HOLD = 50000,
  parameter int unsigned HOLD_W    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] target_sel,
  input  logic       fault,
  output logic       en_out,
  output logic [3:0] freq_adj,
  output logic       busy,
  output logic       at_speed,
  output logic       fault_flag,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    RUN  = 2'd2,
    STOP = 2'd3
  } state_t;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(STEP_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  state_t            state_q, state_n;
  logic [HOLD_W-1:0] hold_q, hold_n;
  logic [3:0]        freq_q, freq_n;
  logic              en_q, en_n;
  logic              flag_q, flag_n;
  logic              busy_q, at_speed_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      freq_q     <= 4'hF;
      en_q       <= 1'b0;
      flag_q     <= 1'b0;
      busy_q     <= 1'b0;
      at_speed_q <= 1'b0;
    end else begin
      state_q    <= state_n;
      hold_q     <= hold_n;
      freq_q     <= freq_n;
      en_q       <= en_n;
      flag_q     <= flag_n;
      busy_q     <= (state_n != IDLE);
      at_speed_q <= (state_n == RUN);
    end
  end

  // hold_n defaults to zero so every state change and every step clears it.
  always_comb begin
    state_n = state_q;
    hold_n  = '0;
    freq_n  = freq_q;
    en_n    = en_q;
    flag_n  = flag_q;
    if (fault) begin
      state_n = IDLE;
      en_n    = 1'b0;
      freq_n  = 4'hF;
      flag_n  = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          en_n   = 1'b0;
          freq_n = 4'hF;
          if (!start) begin
            flag_n = 1'b0;
          end else if (!flag_q) begin
            state_n = RAMP;
            en_n    = 1'b1;
          end
        end
        RAMP: begin
          en_n = 1'b1;
          if (!start) begin
            state_n = STOP;
          end else if (freq_q == target_sel) begin
            state_n = RUN;
          end else if (hold_q == HOLD_LAST) begin
            freq_n = (freq_q > target_sel) ? freq_q - 4'd1 : freq_q + 4'd1;
          end else begin
            hold_n = hold_q + HOLD_ONE;
          end
        end
        RUN: begin
          en_n = 1'b1;
          if (!start) begin
            state_n = STOP;
          end else if (target_sel != freq_q) begin
            state_n = RAMP;
          end
        end
        STOP: begin
          en_n = 1'b1;
          if (start) begin
            state_n = RAMP;
          end else if (hold_q == HOLD_LAST) begin
            if (freq_q == 4'hF) begin
              state_n = IDLE;
              en_n    = 1'b0;
            end else begin
              freq_n = freq_q + 4'd1;
            end
          end else begin
            hold_n = hold_q + HOLD_ONE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign en_out     = en_q;
  assign freq_adj   = freq_q;
  assign busy       = busy_q;
  assign at_speed   = at_speed_q;
  assign fault_flag = flag_q;
  assign state      = state_q;

endmodule

// File: tb/tb_spwm_speed_sequencer.sv
// Directed bench for spwm_speed_sequencer with STEP_HOLD=4; expectations
// are hand-computed edge by edge.
module tb_spwm_speed_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] target_sel;
  logic       fault;
  logic       en_out;
  logic [3:0] freq_adj;
  logic       busy;
  logic       at_speed;
  logic       fault_flag;
  logic [1:0] state;

  int vectors = 0;
  int miscompares = 0;

  spwm_speed_sequencer #(
    .STEP_HOLD(4),
    .HOLD_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .target_sel(target_sel),
    .fault(fault),
    .en_out(en_out),
    .freq_adj(freq_adj),
    .busy(busy),
    .at_speed(at_speed),
    .fault_flag(fault_flag),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] st, input logic en,
                         input logic [3:0] fa, input logic bz, input logic as, input logic ff);
    chk({tag, ".state"}, {2'b00, state}, {2'b00, st});
    chk({tag, ".en_out"}, {3'b000, en_out}, {3'b000, en});
    chk({tag, ".freq_adj"}, freq_adj, fa);
    chk({tag, ".busy"}, {3'b000, busy}, {3'b000, bz});
    chk({tag, ".at_speed"}, {3'b000, at_speed}, {3'b000, as});
    chk({tag, ".fault_flag"}, {3'b000, fault_flag}, {3'b000, ff});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; target_sel = 4'd12; fault = 1'b0;
    step(2);
    chk_all("reset", 2'd0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Start ramp to 12
    start = 1'b1;
    step(1);  chk_all("E1", 2'd1, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0);
    step(3);  chk("E4.freq", freq_adj, 4'd15);
    step(1);  chk("E5.freq", freq_adj, 4'd14);
    step(4);  chk("E9.freq", freq_adj, 4'd13);
    step(4);  chk_all("E13", 2'd1, 1'b1, 4'd12, 1'b1, 1'b0, 1'b0);
    step(1);  chk_all("E14", 2'd2, 1'b1, 4'd12, 1'b1, 1'b1, 1'b0);

    // Stop from RUN at 12
    start = 1'b0;
    step(1);  chk_all("S1", 2'd3, 1'b1, 4'd12, 1'b1, 1'b0, 1'b0);
    step(4);  chk("S5.freq", freq_adj, 4'd13);
    step(4);  chk("S9.freq", freq_adj, 4'd14);
    step(4);  chk("S13.freq", freq_adj, 4'd15);
    chk("S13.state", {2'b00, state}, 4'd3);
    step(3);  chk("S16.state", {2'b00, state}, 4'd3);
    step(1);  chk_all("S17", 2'd0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0);

    // Back to RUN at 12, then retarget to 14
    start = 1'b1; target_sel = 4'd12;
    step(14); chk_all("run12", 2'd2, 1'b1, 4'd12, 1'b1, 1'b1, 1'b0);
    target_sel = 4'd14;
    step(1);  chk_all("retgt", 2'd1, 1'b1, 4'd12, 1'b1, 1'b0, 1'b0);
    step(4);  chk("retgt+4.freq", freq_adj, 4'd13);
    step(4);  chk("retgt+8.freq", freq_adj, 4'd14);
    chk("retgt+8.state", {2'b00, state}, 4'd1);
    step(1);  chk_all("run14", 2'd2, 1'b1, 4'd14, 1'b1, 1'b1, 1'b0);

    // Stop, then restart during STOP at 14 toward 12
    start = 1'b0;
    step(1);  chk_all("stop14", 2'd3, 1'b1, 4'd14, 1'b1, 1'b0, 1'b0);
    start = 1'b1; target_sel = 4'd12;
    step(1);  chk_all("restart", 2'd1, 1'b1, 4'd14, 1'b1, 1'b0, 1'b0);
    step(4);  chk("restart+4.freq", freq_adj, 4'd13);

    // Fault pulse in RAMP at 13
    fault = 1'b1;
    step(1);  chk_all("fault", 2'd0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1);
    fault = 1'b0;
    step(20); chk_all("fault_hold", 2'd0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1);
    start = 1'b0;
    step(1);  chk_all("flag_clr", 2'd0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    step(1);  chk_all("fault_restart", 2'd1, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0);

    // Reset wins over fault and start mid-RAMP
    step(6);  chk("preRst.freq", freq_adj, 4'd14);
    rst = 1'b1; fault = 1'b1;
    step(1);  chk_all("rst1", 2'd0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
    step(1);  chk_all("rst2", 2'd0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
    rst = 1'b0; fault = 1'b0;
    step(1);  chk_all("postRst", 2'd1, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0);

    // target_sel=15: RUN at 15 with en_out high
    target_sel = 4'd15;
    step(1);  chk_all("run15", 2'd2, 1'b1, 4'hF, 1'b1, 1'b1, 1'b0);
    step(3);  chk_all("run15_hold", 2'd2, 1'b1, 4'hF, 1'b1, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
